nios2_ocimem_access_seq: RTL and testbench
==========================================

Name: nios2_ocimem_access_seq

Overview:
- Sysclk-domain sequencer that turns the debug module's one-cycle take_action / take_no_action strobes and the 38-bit jdo word into single-port accesses to the CPU's on-chip debug memory (OCI RAM).
- Holds the current debug address with wrap-around auto-increment, enforces the fixed RAM read latency, and returns read data in MonDReg.
- Drives the monitor_ready handshake back to the JTAG tck-side logic.
- Sits between the debug module's sysclk synchroniser and the OCI RAM, inside the Nios II debug core.

Parameters:
- ADDR_W, 8, word-address width of OCI RAM (256 x 32).
- RD_LAT, 1, RAM read latency in clk cycles; legal values 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- take_action_ocimem_a  in  1  pulse: load address from jdo; optional immediate read.
- take_no_action_ocimem_a  in  1  pulse: read at current address, then increment.
- take_action_ocimem_b  in  1  pulse: write jdo data at current address, then increment.
- jdo  in  38  debug shift-register contents, stable while any strobe is high.
- mem_addr  out  ADDR_W  RAM word address.
- mem_rd  out  1  RAM read strobe, one cycle.
- mem_wr  out  1  RAM write strobe, one cycle.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid RD_LAT cycles after mem_rd.
- MonDReg  out  32  last read data; write data after a write.
- monitor_ready  out  1  high when idle and the last command completed.
- cmd_overrun  out  1  sticky: a command strobe arrived while busy.

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, MonDReg=0, monitor_ready=1, cmd_overrun=0, state=IDLE. Reset mid-operation aborts the access immediately; no strobe is issued after reset_n falls.
- Field decode:
  - Address = jdo[ADDR_W+16:17].
  - Immediate-read flag = jdo[34].
  - Write data = jdo[34:3].
- Strobe priority when more than one is high in the same cycle: action_b > action_a > no_action_a. Lower-priority strobes are ignored and do not set cmd_overrun.
- States:
  - IDLE:
    - action_a: load addr.
      - If jdo[34]=1: mem_rd=1 next cycle, go to RD_WAIT.
      - Else: stay in IDLE; monitor_ready stays 1.
    - no_action_a: mem_rd=1 next cycle, go to RD_WAIT.
    - action_b: mem_wr=1 and mem_wdata=jdo[34:3] next cycle, go to WR.
    - Any accepted command drops monitor_ready to 0 in the cycle after the strobe, except an address-only load.
  - WR (1 cycle):
    - MonDReg <= mem_wdata.
    - addr <= addr+1.
    - Go to IDLE; monitor_ready=1.
  - RD_WAIT: count RD_LAT cycles from the mem_rd cycle, then sample mem_rdata into MonDReg, addr <= addr+1, go to IDLE; monitor_ready=1 the same cycle MonDReg updates.
  - A read therefore completes with monitor_ready=1 exactly RD_LAT+1 cycles after the strobe.
- Address increment is modulo 2^ADDR_W: 0xFF -> 0x00 with ADDR_W=8.
- An address-only action_a does not increment.
- mem_rd and mem_wr are never high together and each lasts exactly one cycle.
- Any strobe while state != IDLE:
  - The command is dropped and cmd_overrun is set to 1.
  - The in-flight access completes normally.
- cmd_overrun is cleared only by an accepted action_a. If the clearing action_a is itself dropped, the flag stays set.

Optional Feature:
- Macro: OCIMEM_WRITE_PROTECT_EN.
- When defined, adds parameter PROT_BASE (default 2^ADDR_W-32).
  - An action_b with addr >= PROT_BASE issues no mem_wr.
  - The address still increments, MonDReg is unchanged, and sticky output wr_prot_err is set.
  - wr_prot_err clears on an accepted action_a.
- When undefined: no wr_prot_err port, all addresses are writable, and behaviour is otherwise identical.

Test Plan:
1. Reset, then action_a with addr=0x10 and jdo[34]=0 -> mem_addr=0x10, no mem_rd, monitor_ready stays 1.
2. Preload RAM[0x10]=0xDEADBEEF; action_a with addr=0x10 and jdo[34]=1, RD_LAT=1 -> mem_rd pulses once; MonDReg=0xDEADBEEF and monitor_ready=1 two cycles after the strobe; mem_addr=0x11.
3. Set addr=0xFE; two action_b strobes with data 0x11111111 and 0x22222222, spaced 3 cycles apart -> RAM[0xFE] and RAM[0xFF] written, mem_addr wraps to 0x00, MonDReg=0x22222222.
4. RD_LAT=3: no_action_a, then a second no_action_a one cycle later -> second command dropped, cmd_overrun=1, single mem_rd; a later action_a clears cmd_overrun.
5. action_b and no_action_a high in the same cycle -> only mem_wr is issued, cmd_overrun=0.
6. Assert reset_n=0 during RD_WAIT -> all outputs return to reset values at once; no late MonDReg update after reset is released.

Source files
------------

// File: rtl/nios2_ocimem_access_seq_if.sv
// Command and OCI RAM bundle between the debug-module strobes, the RAM and the access sequencer.
// Optional macro OCIMEM_WRITE_PROTECT_EN adds the sticky wr_prot_err flag.
//
// Handshake: each take_* strobe is a one-cycle command that is accepted only while
// seq_state is IDLE; strobes seen while busy are dropped and raise cmd_overrun.
// monitor_ready is high once the last accepted command has completed and the
// sequencer is idle again; mem_rd / mem_wr are single-cycle, never together.
interface nios2_ocimem_access_seq_if #(
    parameter int ADDR_W = 8
);
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [37:0]       jdo;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              cmd_overrun;
    logic [1:0]        seq_state;
`ifdef OCIMEM_WRITE_PROTECT_EN
    logic              wr_prot_err;
`endif

    modport master (
        output take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output jdo, mem_rdata,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, MonDReg, monitor_ready,
        input  cmd_overrun, seq_state
`ifdef OCIMEM_WRITE_PROTECT_EN
        , input wr_prot_err
`endif
    );

    modport slave (
        input  take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  jdo, mem_rdata,
        output mem_addr, mem_rd, mem_wr, mem_wdata, MonDReg, monitor_ready,
        output cmd_overrun, seq_state
`ifdef OCIMEM_WRITE_PROTECT_EN
        , output wr_prot_err
`endif
    );
endinterface

// File: rtl/nios2_ocimem_access_seq.sv
// Sysclk sequencer turning debug strobes + jdo into single-port OCI RAM reads/writes.
// Optional macro OCIMEM_WRITE_PROTECT_EN blocks writes at or above PROT_BASE.
module nios2_ocimem_access_seq #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
`ifdef OCIMEM_WRITE_PROTECT_EN
    , parameter int PROT_BASE = (1 << ADDR_W) - 32
`endif
) (
    input logic                     clk,
    input logic                     reset_n,
    nios2_ocimem_access_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              rd, rd_n;
    logic              wr, wr_n;
    logic [31:0]       wdata, wdata_n;
    logic [31:0]       mon, mon_n;
    logic              ready, ready_n;
    logic              ovr, ovr_n;
    logic [1:0]        cnt, cnt_n;
    logic              wr_allowed;
    logic              any_strobe;

    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_rd;
    logic [31:0]       jdo_wdata;
    logic              unused_jdo;

    assign jdo_addr   = bus.jdo[ADDR_W+16:17];
    assign jdo_rd     = bus.jdo[34];
    assign jdo_wdata  = bus.jdo[34:3];
    assign unused_jdo = &{1'b0, bus.jdo[37:35], bus.jdo[2:0]};

    assign any_strobe = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a
                      | bus.take_action_ocimem_b;

`ifdef OCIMEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] PROT_A = (ADDR_W+1)'(PROT_BASE);
    logic prot_err, prot_err_n;
    assign wr_allowed = ({1'b0, addr} < PROT_A);
`else
    assign wr_allowed = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            addr  <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            wdata <= '0;
            mon   <= '0;
            ready <= 1'b1;
            ovr   <= 1'b0;
            cnt   <= '0;
`ifdef OCIMEM_WRITE_PROTECT_EN
            prot_err <= 1'b0;
`endif
        end else begin
            state <= state_n;
            addr  <= addr_n;
            rd    <= rd_n;
            wr    <= wr_n;
            wdata <= wdata_n;
            mon   <= mon_n;
            ready <= ready_n;
            ovr   <= ovr_n;
            cnt   <= cnt_n;
`ifdef OCIMEM_WRITE_PROTECT_EN
            prot_err <= prot_err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        wdata_n = wdata;
        mon_n   = mon;
        ready_n = ready;
        ovr_n   = ovr;
        cnt_n   = cnt;
`ifdef OCIMEM_WRITE_PROTECT_EN
        prot_err_n = prot_err;
`endif
        unique case (state)
            IDLE: begin
                // Priority b > a > no_action; losers in the same cycle are simply ignored.
                if (bus.take_action_ocimem_b) begin
                    wdata_n = jdo_wdata;
                    wr_n    = wr_allowed;
                    ready_n = 1'b0;
                    state_n = WR;
`ifdef OCIMEM_WRITE_PROTECT_EN
                    if (!wr_allowed) prot_err_n = 1'b1;
`endif
                end else if (bus.take_action_ocimem_a) begin
                    addr_n = jdo_addr;
                    ovr_n  = 1'b0;
`ifdef OCIMEM_WRITE_PROTECT_EN
                    prot_err_n = 1'b0;
`endif
                    if (jdo_rd) begin
                        rd_n    = 1'b1;
                        cnt_n   = '0;
                        ready_n = 1'b0;
                        state_n = RD_WAIT;
                    end
                end else if (bus.take_no_action_ocimem_a) begin
                    rd_n    = 1'b1;
                    cnt_n   = '0;
                    ready_n = 1'b0;
                    state_n = RD_WAIT;
                end
            end
            WR: begin
                // A protected write left wr low, so MonDReg keeps its old value.
                if (wr) mon_n = wdata;
                addr_n  = addr + ADDR_W'(1);
                ready_n = 1'b1;
                state_n = IDLE;
                if (any_strobe) ovr_n = 1'b1;
            end
            RD_WAIT: begin
                // cnt is 0 in the mem_rd cycle; data is sampled RD_LAT cycles later.
                if (cnt == LAT_LAST) begin
                    mon_n   = bus.mem_rdata;
                    addr_n  = addr + ADDR_W'(1);
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
                if (any_strobe) ovr_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_addr      = addr;
    assign bus.mem_rd        = rd;
    assign bus.mem_wr        = wr;
    assign bus.mem_wdata     = wdata;
    assign bus.MonDReg       = mon;
    assign bus.monitor_ready = ready;
    assign bus.cmd_overrun   = ovr;
    assign bus.seq_state     = state;
`ifdef OCIMEM_WRITE_PROTECT_EN
    assign bus.wr_prot_err   = prot_err;
`endif

endmodule

// File: tb/tb_nios2_ocimem_access_seq.sv
// Bench for nios2_ocimem_access_seq: a RD_LAT=1 and a RD_LAT=3 instance, each with its own RAM.
// Table vectors, hand sequences for overrun/reset, and random traffic against a timeline model.
module tb_nios2_ocimem_access_seq;

    typedef struct packed {
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] mon;
        logic        ready;
        logic        ovr;
    } obs_t;

    typedef struct {
        logic        a;
        logic        na;
        logic        b;
        logic [37:0] jdo;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        s_a, s_na, s_b, sel;
    logic [37:0] s_jdo;
    int          n_checks = 0;
    int          n_fail   = 0;

    nios2_ocimem_access_seq_if #(.ADDR_W(8)) ifa ();
    nios2_ocimem_access_seq_if #(.ADDR_W(8)) ifb ();

    nios2_ocimem_access_seq #(.ADDR_W(8), .RD_LAT(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    nios2_ocimem_access_seq #(.ADDR_W(8), .RD_LAT(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    assign ifa.take_action_ocimem_a    = s_a  & ~sel;
    assign ifa.take_no_action_ocimem_a = s_na & ~sel;
    assign ifa.take_action_ocimem_b    = s_b  & ~sel;
    assign ifb.take_action_ocimem_a    = s_a  & sel;
    assign ifb.take_no_action_ocimem_a = s_na & sel;
    assign ifb.take_action_ocimem_b    = s_b  & sel;
    assign ifa.jdo = s_jdo;
    assign ifb.jdo = s_jdo;

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
    endfunction

    // Behavioural RAMs with registered read pipelines.
    logic [31:0] ram_a[256];
    logic [31:0] ram_b[256];
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    assign ifa.mem_rdata = pa[0];
    assign ifb.mem_rdata = pb[2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] <= init_word(i);
            ram_b[i] <= init_word(i);
        end
        for (int i = 0; i < 3; i++) begin
            pa[i] <= 32'h0;
            pb[i] <= 32'h0;
        end
        forever begin
            @(posedge clk);
            if (ifa.mem_wr) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
            if (ifb.mem_wr) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
            pa[0] <= ifa.mem_rd ? ram_a[ifa.mem_addr] : 32'h0;
            pb[0] <= ifb.mem_rd ? ram_b[ifb.mem_addr] : 32'h0;
            pb[1] <= pb[0];
            pb[2] <= pb[1];
        end
    end

    obs_t obs;
    always_comb begin
        if (sel) obs = '{addr: ifb.mem_addr, rd: ifb.mem_rd, wr: ifb.mem_wr, wdata: ifb.mem_wdata,
                         mon: ifb.MonDReg, ready: ifb.monitor_ready, ovr: ifb.cmd_overrun};
        else     obs = '{addr: ifa.mem_addr, rd: ifa.mem_rd, wr: ifa.mem_wr, wdata: ifa.mem_wdata,
                         mon: ifa.MonDReg, ready: ifa.monitor_ready, ovr: ifa.cmd_overrun};
    end

    function automatic obs_t mk_obs(input logic [7:0] addr, input logic rd, input logic wr,
                                    input logic [31:0] wdata, input logic [31:0] mon,
                                    input logic ready, input logic ovr);
        return '{addr: addr, rd: rd, wr: wr, wdata: wdata, mon: mon, ready: ready, ovr: ovr};
    endfunction

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rdf);
        return {3'b0, rdf, 9'b0, addr, 17'b0};
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        return {3'b0, data, 3'b0};
    endfunction

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic na, input logic b, input logic [37:0] j);
        @(negedge clk);
        s_a = a; s_na = na; s_b = b; s_jdo = j;
        @(posedge clk);
        #1;
        s_a = 1'b0; s_na = 1'b0; s_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // Timeline model: commands are accepted only when no earlier command is still pending.
    logic [31:0] mdl_mem[256];
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_mon;
    logic        m_rd, m_wr, m_ready, m_ovr;
    int          m_kind, m_done, m_edge, m_lat;

    task automatic mdl_init(input int inst);
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
        if (inst == 0) begin
            mdl_mem[8'hFE] = 32'h11111111;
            mdl_mem[8'hFF] = 32'h22222222;
            mdl_mem[8'h00] = 32'h33333333;
            mdl_mem[8'h01] = 32'h44444444;
            mdl_mem[8'h31] = 32'h55555555;
        end
        m_lat = (inst == 0) ? 1 : 3;
        m_addr = 8'h0; m_wdata = 32'h0; m_mon = 32'h0;
        m_rd = 1'b0; m_wr = 1'b0; m_ready = 1'b1; m_ovr = 1'b0;
        m_kind = 0; m_done = 0; m_edge = 0;
    endtask

    task automatic mdl_step(input logic a, input logic na, input logic b, input logic [37:0] j);
        bit busy;
        busy = (m_kind != 0);
        m_rd = 1'b0;
        m_wr = 1'b0;
        if (busy && m_edge == m_done) begin
            if (m_kind == 1) begin
                m_mon = mdl_mem[m_addr];
            end else begin
                mdl_mem[m_addr] = m_wdata;
                m_mon = m_wdata;
            end
            m_addr  = m_addr + 8'd1;
            m_ready = 1'b1;
            m_kind  = 0;
        end
        if (busy) begin
            if (a | na | b) m_ovr = 1'b1;
        end else if (b) begin
            m_wdata = j[34:3];
            m_wr = 1'b1; m_kind = 2; m_done = m_edge + 1; m_ready = 1'b0;
        end else if (a) begin
            m_addr = j[24:17];
            m_ovr  = 1'b0;
            if (j[34]) begin
                m_rd = 1'b1; m_kind = 1; m_done = m_edge + m_lat + 1; m_ready = 1'b0;
            end
        end else if (na) begin
            m_rd = 1'b1; m_kind = 1; m_done = m_edge + m_lat + 1; m_ready = 1'b0;
        end
        m_edge++;
    endtask

    vec_t tbl[21];

    initial begin
        obs_t rst_obs;
        int   rd_cnt;
        rst_obs = mk_obs(8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        tbl[0]  = '{1, 0, 0, jdo_a(8'h10, 1'b0), mk_obs(8'h10, 0, 0, 32'h0, 32'h0, 1, 0)};
        tbl[1]  = '{0, 0, 0, 38'h0,              mk_obs(8'h10, 0, 0, 32'h0, 32'h0, 1, 0)};
        tbl[2]  = '{1, 0, 0, jdo_a(8'h10, 1'b1), mk_obs(8'h10, 1, 0, 32'h0, 32'h0, 0, 0)};
        tbl[3]  = '{0, 0, 0, 38'h0,              mk_obs(8'h10, 0, 0, 32'h0, 32'h0, 0, 0)};
        tbl[4]  = '{0, 0, 0, 38'h0,              mk_obs(8'h11, 0, 0, 32'h0, 32'hDEADBEEF, 1, 0)};
        tbl[5]  = '{1, 0, 0, jdo_a(8'hFE, 1'b0), mk_obs(8'hFE, 0, 0, 32'h0, 32'hDEADBEEF, 1, 0)};
        tbl[6]  = '{0, 0, 1, jdo_b(32'h11111111), mk_obs(8'hFE, 0, 1, 32'h11111111, 32'hDEADBEEF, 0, 0)};
        tbl[7]  = '{0, 0, 0, 38'h0, mk_obs(8'hFF, 0, 0, 32'h11111111, 32'h11111111, 1, 0)};
        tbl[8]  = '{0, 0, 0, 38'h0, mk_obs(8'hFF, 0, 0, 32'h11111111, 32'h11111111, 1, 0)};
        tbl[9]  = '{0, 0, 1, jdo_b(32'h22222222), mk_obs(8'hFF, 0, 1, 32'h22222222, 32'h11111111, 0, 0)};
        tbl[10] = '{0, 0, 0, 38'h0, mk_obs(8'h00, 0, 0, 32'h22222222, 32'h22222222, 1, 0)};
        tbl[11] = '{0, 1, 1, jdo_b(32'h33333333), mk_obs(8'h00, 0, 1, 32'h33333333, 32'h22222222, 0, 0)};
        tbl[12] = '{0, 0, 0, 38'h0, mk_obs(8'h01, 0, 0, 32'h33333333, 32'h33333333, 1, 0)};
        tbl[13] = '{0, 0, 1, jdo_b(32'h44444444), mk_obs(8'h01, 0, 1, 32'h44444444, 32'h33333333, 0, 0)};
        tbl[14] = '{0, 1, 0, 38'h0, mk_obs(8'h02, 0, 0, 32'h44444444, 32'h44444444, 1, 1)};
        tbl[15] = '{1, 0, 0, jdo_a(8'h20, 1'b0), mk_obs(8'h20, 0, 0, 32'h44444444, 32'h44444444, 1, 0)};
        tbl[16] = '{1, 1, 0, jdo_a(8'h30, 1'b1), mk_obs(8'h30, 1, 0, 32'h44444444, 32'h44444444, 0, 0)};
        tbl[17] = '{0, 0, 0, 38'h0, mk_obs(8'h30, 0, 0, 32'h44444444, 32'h44444444, 0, 0)};
        tbl[18] = '{0, 0, 0, 38'h0, mk_obs(8'h31, 0, 0, 32'h44444444, 32'hC0DE0030, 1, 0)};
        tbl[19] = '{1, 1, 1, jdo_b(32'h55555555), mk_obs(8'h31, 0, 1, 32'h55555555, 32'hC0DE0030, 0, 0)};
        tbl[20] = '{0, 0, 0, 38'h0, mk_obs(8'h32, 0, 0, 32'h55555555, 32'h55555555, 1, 0)};

        reset_n = 1'b0; sel = 1'b0;
        s_a = 1'b0; s_na = 1'b0; s_b = 1'b0; s_jdo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_lat1", obs, rst_obs);
        sel = 1'b1;
        #1;
        chk("reset_lat3", obs, rst_obs);
        sel = 1'b0;
        #1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].a, tbl[i].na, tbl[i].b, tbl[i].jdo);
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end
        chk("ram_fe", 76'(ram_a[8'hFE]), 76'(32'h11111111));
        chk("ram_ff", 76'(ram_a[8'hFF]), 76'(32'h22222222));
        chk("ram_00", 76'(ram_a[8'h00]), 76'(32'h33333333));
        chk("ram_01", 76'(ram_a[8'h01]), 76'(32'h44444444));
        chk("ram_31", 76'(ram_a[8'h31]), 76'(32'h55555555));

        // RD_LAT=3: second read while busy is dropped, single mem_rd, completion 4 cycles after strobe.
        sel = 1'b1;
        do_reset();
        rd_cnt = 0;
        step(0, 1, 0, 38'h0);
        rd_cnt += int'(obs.rd);
        chk("ovr_e0", obs, mk_obs(8'h00, 1, 0, 32'h0, 32'h0, 0, 0));
        step(0, 1, 0, 38'h0);
        rd_cnt += int'(obs.rd);
        chk("ovr_e1", obs, mk_obs(8'h00, 0, 0, 32'h0, 32'h0, 0, 1));
        step(0, 0, 0, 38'h0);
        rd_cnt += int'(obs.rd);
        step(0, 0, 0, 38'h0);
        rd_cnt += int'(obs.rd);
        chk("ovr_e3", obs, mk_obs(8'h00, 0, 0, 32'h0, 32'h0, 0, 1));
        step(0, 0, 0, 38'h0);
        rd_cnt += int'(obs.rd);
        chk("ovr_e4", obs, mk_obs(8'h01, 0, 0, 32'h0, 32'hC0DE0000, 1, 1));
        chk("ovr_rdcount", 76'(rd_cnt), 76'(1));
        step(1, 0, 0, jdo_a(8'h05, 1'b0));
        chk("ovr_clear", obs, mk_obs(8'h05, 0, 0, 32'h0, 32'hC0DE0000, 1, 0));
        step(0, 1, 0, 38'h0);
        step(1, 0, 0, jdo_a(8'h09, 1'b0));
        chk("ovr_drop_a", obs, mk_obs(8'h05, 0, 0, 32'h0, 32'hC0DE0000, 0, 1));
        repeat (3) step(0, 0, 0, 38'h0);
        chk("ovr_sticky", obs, mk_obs(8'h06, 0, 0, 32'h0, 32'hC0DE0005, 1, 1));

        // Reset during RD_WAIT: immediate return to reset values, no late completion.
        step(0, 1, 0, 38'h0);
        step(0, 0, 0, 38'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", obs, rst_obs);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 38'h0);
            chk($sformatf("rst_quiet%0d", i), obs, rst_obs);
        end

        for (int inst = 0; inst < 2; inst++) begin
            sel = (inst == 1);
            do_reset();
            mdl_init(inst);
            for (int n = 0; n < 300; n++) begin
                logic        a, na, b;
                logic [63:0] r;
                logic [37:0] j;
                int          k;
                k = $urandom_range(0, 9);
                a = (k <= 1); na = (k == 2 || k == 3); b = (k == 4 || k == 5);
                if (k == 6) {a, na, b} = 3'($urandom_range(0, 7));
                r = {$urandom(), $urandom()};
                j = r[37:0];
                j[24:17] = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3))
                                                       : 8'(8'h40 + $urandom_range(0, 7));
                mdl_step(a, na, b, j);
                step(a, na, b, j);
                chk($sformatf("rnd%0d_%0d", inst, n), obs,
                    mk_obs(m_addr, m_rd, m_wr, m_wdata, m_mon, m_ready, m_ovr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
